demux1an_rr_param: RTL and testbench

//  Parametrised 1-to-N byte-lane demultiplexer for the PHY receive path.

---
 rtl/demux1an_rr_param.sv | 120 ++++++++++++
 tb/tb_demux1an_rr_param.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1an_rr_param.sv
// Parametrised 1-to-N word demultiplexer for the PHY receive path.
// Stripes a valid-qualified word stream over NCH lanes round-robin or by explicit lane select.
module demux1an_rr_param #(
   parameter int WIDTH    = 8,
   parameter int NCH      = 4,
   parameter int SELW     = 2,
   parameter int IDLE_GAP = 4
) (
   input  logic                 clk_4f,
   input  logic                 reset_L,
   input  logic                 valid,
   input  logic [WIDTH-1:0]     data_in,
   input  logic                 mode_sel,
   input  logic [SELW-1:0]      sel_in,
   input  logic                 sync,
   output logic [NCH-1:0]       validout,
   output logic [NCH*WIDTH-1:0] dataout,
   output logic [SELW-1:0]      lane_ptr,
   output logic                 err_sel
);

   localparam int GAPW = $clog2(IDLE_GAP + 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t          state_r;
   state_t          state_s;
   logic [GAPW-1:0] gap_r;
   logic [GAPW-1:0] gap_s;
   logic [SELW-1:0] ptr_s;
   logic [SELW-1:0] tgt_s;
   logic            route_s;
   logic            err_s;
   logic [NCH-1:0]  vout_s;

   // Next-state, pointer, gap counter and routing decision; sync overrides everything else
   always_comb begin
      state_s = state_r;
      gap_s   = gap_r;
      ptr_s   = lane_ptr;
      tgt_s   = {SELW{1'b0}};
      route_s = 1'b0;
      err_s   = 1'b0;
      if (sync) begin
         gap_s = {GAPW{1'b0}};
         if (valid) begin
            route_s = 1'b1;
            state_s = ST_RUN;
            ptr_s   = mode_sel ? {SELW{1'b0}} : SELW'(1);
         end else begin
            state_s = ST_IDLE;
            ptr_s   = {SELW{1'b0}};
         end
      end else if (valid) begin
         gap_s   = {GAPW{1'b0}};
         state_s = ST_RUN;
         if (mode_sel) begin
            if (32'(sel_in) < 32'(NCH)) begin
               route_s = 1'b1;
               tgt_s   = sel_in;
            end else begin
               err_s = 1'b1;
            end
         end else begin
            // In IDLE the pointer is already 0, so the first word lands on lane 0
            route_s = 1'b1;
            tgt_s   = lane_ptr;
            ptr_s   = (lane_ptr == SELW'(NCH - 1)) ? {SELW{1'b0}} : lane_ptr + 1'b1;
         end
      end else if (state_r == ST_RUN) begin
         if (gap_r == GAPW'(IDLE_GAP - 1)) begin
            state_s = ST_IDLE;
            gap_s   = {GAPW{1'b0}};
            ptr_s   = {SELW{1'b0}};
         end else begin
            gap_s = gap_r + 1'b1;
         end
      end else begin
         gap_s = {GAPW{1'b0}};
         ptr_s = {SELW{1'b0}};
      end
   end

   // One-hot lane strobe for the routed word
   always_comb begin
      vout_s = {NCH{1'b0}};
      if (route_s) begin
         vout_s = {{(NCH-1){1'b0}}, 1'b1} << tgt_s;
      end else begin
         vout_s = {NCH{1'b0}};
      end
   end

   // State and output registers; lanes not strobed hold their last word
   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) begin
         state_r  <= ST_IDLE;
         gap_r    <= {GAPW{1'b0}};
         lane_ptr <= {SELW{1'b0}};
         validout <= {NCH{1'b0}};
         dataout  <= {(NCH*WIDTH){1'b0}};
         err_sel  <= 1'b0;
      end else begin
         state_r  <= state_s;
         gap_r    <= gap_s;
         lane_ptr <= ptr_s;
         validout <= vout_s;
         err_sel  <= err_s;
         for (int i = 0; i < NCH; i++) begin
            if (vout_s[i]) begin
               dataout[i*WIDTH +: WIDTH] <= data_in;
            end
         end
      end
   end

endmodule

// File: tb/tb_demux1an_rr_param.sv
// Self-checking bench for demux1an_rr_param: three instances (8b x4, 8b x3, 16b x2)
// share one stimulus stream; directed scenarios plus a randomized run against a lane-level model.
module tb_demux1an_rr_param;

   logic        clk_4f = 1'b0;
   logic        reset_L = 1'b0;
   logic        valid = 1'b0;
   logic        mode_sel = 1'b0;
   logic        sync = 1'b0;
   logic [1:0]  sel = 2'd0;
   logic [15:0] din = 16'd0;

   logic [3:0]  vo0;  logic [31:0] do0;  logic [1:0] lp0;  logic er0;
   logic [2:0]  vo1;  logic [23:0] do1;  logic [1:0] lp1;  logic er1;
   logic [1:0]  vo2;  logic [31:0] do2;  logic [0:0] lp2;  logic er2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk_4f = ~clk_4f;

   demux1an_rr_param #(.WIDTH(8), .NCH(4), .SELW(2), .IDLE_GAP(4)) u0 (
      .clk_4f(clk_4f), .reset_L(reset_L), .valid(valid), .data_in(din[7:0]),
      .mode_sel(mode_sel), .sel_in(sel), .sync(sync),
      .validout(vo0), .dataout(do0), .lane_ptr(lp0), .err_sel(er0));

   demux1an_rr_param #(.WIDTH(8), .NCH(3), .SELW(2), .IDLE_GAP(4)) u1 (
      .clk_4f(clk_4f), .reset_L(reset_L), .valid(valid), .data_in(din[7:0]),
      .mode_sel(mode_sel), .sel_in(sel), .sync(sync),
      .validout(vo1), .dataout(do1), .lane_ptr(lp1), .err_sel(er1));

   demux1an_rr_param #(.WIDTH(16), .NCH(2), .SELW(1), .IDLE_GAP(4)) u2 (
      .clk_4f(clk_4f), .reset_L(reset_L), .valid(valid), .data_in(din),
      .mode_sel(mode_sel), .sel_in(sel[0:0]), .sync(sync),
      .validout(vo2), .dataout(do2), .lane_ptr(lp2), .err_sel(er2));

   // Lane-level reference model, one slot per instance
   int          nch_of[3] = '{4, 3, 2};
   int          w_of[3]   = '{8, 8, 16};
   bit          m_act[3];
   int          m_gap[3];
   int          m_ptr[3];
   int          m_hit[3];
   bit          m_err[3];
   logic [15:0] m_lane[3][4];

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_act[k] = 1'b0; m_gap[k] = 0; m_ptr[k] = 0; m_hit[k] = -1; m_err[k] = 1'b0;
         for (int i = 0; i < 4; i++) m_lane[k][i] = 16'd0;
      end
   endtask

   task automatic model_step(input bit v, input bit ms, input bit sy, input int s, input logic [15:0] d);
      for (int k = 0; k < 3; k++) begin
         int          sk;
         logic [15:0] dk;
         sk = (k == 2) ? (s % 2) : s;
         dk = (w_of[k] == 8) ? (d & 16'h00FF) : d;
         m_hit[k] = -1;
         m_err[k] = 1'b0;
         if (sy) begin
            m_gap[k] = 0;
            m_act[k] = v;
            if (v) m_hit[k] = 0;
            m_ptr[k] = (v && !ms) ? 1 : 0;
         end else if (v) begin
            m_gap[k] = 0;
            m_act[k] = 1'b1;
            if (ms) begin
               if (sk < nch_of[k]) m_hit[k] = sk;
               else m_err[k] = 1'b1;
            end else begin
               m_hit[k] = m_ptr[k];
               m_ptr[k] = (m_ptr[k] + 1) % nch_of[k];
            end
         end else if (m_act[k]) begin
            m_gap[k]++;
            if (m_gap[k] == 4) begin
               m_act[k] = 1'b0; m_gap[k] = 0; m_ptr[k] = 0;
            end
         end
         if (m_hit[k] >= 0) m_lane[k][m_hit[k]] = dk;
      end
   endtask

   task automatic drive(input bit v, input bit ms, input int s, input logic [15:0] d, input bit sy);
      valid = v; mode_sel = ms; sel = 2'(s); din = d; sync = sy;
      @(posedge clk_4f);
      #1;
   endtask

   task automatic do_reset();
      valid = 1'b0; mode_sel = 1'b0; sync = 1'b0; sel = 2'd0; din = 16'd0;
      reset_L = 1'b0;
      @(posedge clk_4f);
      #1;
      reset_L = 1'b1;
   endtask

   task automatic test_reset();
      reset_L = 1'b0;
      #3;
      n_cmp++; if ({vo0, do0, lp0, er0} !== 39'd0) begin n_bad++; $display("FAIL reset_u0 got %h want 0", {vo0, do0, lp0, er0}); end
      n_cmp++; if ({vo1, do1, lp1, er1} !== 30'd0) begin n_bad++; $display("FAIL reset_u1 got %h want 0", {vo1, do1, lp1, er1}); end
      n_cmp++; if ({vo2, do2, lp2, er2} !== 36'd0) begin n_bad++; $display("FAIL reset_u2 got %h want 0", {vo2, do2, lp2, er2}); end
      do_reset();
      drive(1'b0, 1'b0, 0, 16'd0, 1'b0);
      n_cmp++; if ({vo0, do0, lp0} !== 38'd0) begin n_bad++; $display("FAIL reset_hold got %h want 0", {vo0, do0, lp0}); end
   endtask

   task automatic test_rr_stripe();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, 0, 16'(8'h11 + i), 1'b0);
         n_cmp++; if (vo0 !== 4'(1 << (i % 4))) begin n_bad++; $display("FAIL rr_valid[%0d] got %b want %b", i, vo0, 4'(1 << (i % 4))); end
         n_cmp++; if (do0[(i % 4)*8 +: 8] !== 8'(8'h11 + i)) begin n_bad++; $display("FAIL rr_data[%0d] got %h want %h", i, do0[(i % 4)*8 +: 8], 8'(8'h11 + i)); end
         n_cmp++; if (lp0 !== 2'((i + 1) % 4)) begin n_bad++; $display("FAIL rr_ptr[%0d] got %0d want %0d", i, lp0, (i + 1) % 4); end
      end
      drive(1'b0, 1'b0, 0, 16'd0, 1'b0);
      n_cmp++; if (vo0 !== 4'd0 || do0 !== 32'h1817_1615) begin n_bad++; $display("FAIL rr_hold got %b/%h want 0000/18171615", vo0, do0); end
   endtask

   task automatic test_idle_rewind();
      do_reset();
      drive(1'b1, 1'b0, 0, 16'h01, 1'b0);
      drive(1'b1, 1'b0, 0, 16'h02, 1'b0);
      repeat (3) drive(1'b0, 1'b0, 0, 16'h00, 1'b0);
      drive(1'b1, 1'b0, 0, 16'hAA, 1'b0);
      n_cmp++; if (vo0 !== 4'b0100 || do0[23:16] !== 8'hAA) begin n_bad++; $display("FAIL gap3 got %b/%h want 0100/aa", vo0, do0[23:16]); end
      repeat (4) drive(1'b0, 1'b0, 0, 16'h00, 1'b0);
      n_cmp++; if (lp0 !== 2'd0) begin n_bad++; $display("FAIL gap4_ptr got %0d want 0", lp0); end
      drive(1'b1, 1'b0, 0, 16'hBB, 1'b0);
      n_cmp++; if (vo0 !== 4'b0001 || do0[7:0] !== 8'hBB) begin n_bad++; $display("FAIL rewind got %b/%h want 0001/bb", vo0, do0[7:0]); end
   endtask

   task automatic test_explicit_sel();
      do_reset();
      drive(1'b1, 1'b0, 0, 16'h01, 1'b0);
      drive(1'b1, 1'b1, 3, 16'h5A, 1'b0);
      n_cmp++; if (vo0 !== 4'b1000 || do0[31:24] !== 8'h5A || lp0 !== 2'd1) begin n_bad++; $display("FAIL sel3 got %b/%h/%0d want 1000/5a/1", vo0, do0[31:24], lp0); end
      n_cmp++; if (er1 !== 1'b1 || vo1 !== 3'd0 || er0 !== 1'b0) begin n_bad++; $display("FAIL sel_err got er1=%b vo1=%b er0=%b want 1/000/0", er1, vo1, er0); end
      drive(1'b1, 1'b1, 1, 16'h5B, 1'b0);
      n_cmp++; if (vo0 !== 4'b0010 || do0[15:8] !== 8'h5B || do0[31:24] !== 8'h5A) begin n_bad++; $display("FAIL sel1 got %b/%h want 0010/5a..5b..", vo0, do0); end
      n_cmp++; if (er1 !== 1'b0) begin n_bad++; $display("FAIL err_pulse got %b want 0", er1); end
      drive(1'b1, 1'b1, 3, 16'h5C, 1'b0);
      n_cmp++; if (vo0 !== 4'b1000 || do0[31:24] !== 8'h5C || lp0 !== 2'd1) begin n_bad++; $display("FAIL sel3b got %b/%h/%0d want 1000/5c/1", vo0, do0[31:24], lp0); end
      drive(1'b1, 1'b0, 0, 16'h66, 1'b0);
      n_cmp++; if (vo0 !== 4'b0010 || lp0 !== 2'd2) begin n_bad++; $display("FAIL mode_back got %b/%0d want 0010/2", vo0, lp0); end
   endtask

   task automatic test_sync();
      do_reset();
      drive(1'b1, 1'b0, 0, 16'h01, 1'b0);
      drive(1'b1, 1'b0, 0, 16'h02, 1'b0);
      drive(1'b1, 1'b0, 0, 16'hC3, 1'b1);
      n_cmp++; if (vo0 !== 4'b0001 || do0[7:0] !== 8'hC3 || lp0 !== 2'd1) begin n_bad++; $display("FAIL sync_v got %b/%h/%0d want 0001/c3/1", vo0, do0[7:0], lp0); end
      drive(1'b1, 1'b0, 0, 16'h04, 1'b0);
      drive(1'b0, 1'b0, 0, 16'h00, 1'b1);
      n_cmp++; if (vo0 !== 4'b0000 || lp0 !== 2'd0) begin n_bad++; $display("FAIL sync_nv got %b/%0d want 0000/0", vo0, lp0); end
   endtask

   task automatic test_async_reset();
      do_reset();
      drive(1'b1, 1'b0, 0, 16'h31, 1'b0);
      drive(1'b1, 1'b0, 0, 16'h32, 1'b0);
      #3;
      reset_L = 1'b0;
      #1;
      n_cmp++; if ({vo0, do0, lp0} !== 38'd0) begin n_bad++; $display("FAIL async_rst got %h want 0", {vo0, do0, lp0}); end
      n_cmp++; if ({vo2, do2, lp2} !== 35'd0) begin n_bad++; $display("FAIL async_rst2 got %h want 0", {vo2, do2, lp2}); end
      @(posedge clk_4f);
      #1;
      reset_L = 1'b1;
      drive(1'b1, 1'b0, 0, 16'h77, 1'b0);
      n_cmp++; if (vo0 !== 4'b0001 || do0 !== 32'h0000_0077 || lp0 !== 2'd1) begin n_bad++; $display("FAIL post_rst got %b/%h/%0d want 0001/00000077/1", vo0, do0, lp0); end
   endtask

   task automatic test_wide();
      do_reset();
      drive(1'b1, 1'b0, 0, 16'h1234, 1'b0);
      n_cmp++; if (vo2 !== 2'b01 || do2 !== 32'h0000_1234) begin n_bad++; $display("FAIL wide0 got %b/%h want 01/00001234", vo2, do2); end
      drive(1'b1, 1'b0, 0, 16'hABCD, 1'b0);
      n_cmp++; if (vo2 !== 2'b10 || do2 !== 32'hABCD_1234 || lp2 !== 1'b0) begin n_bad++; $display("FAIL wide1 got %b/%h/%0d want 10/abcd1234/0", vo2, do2, lp2); end
      drive(1'b1, 1'b0, 0, 16'h5555, 1'b0);
      n_cmp++; if (vo2 !== 2'b01 || do2 !== 32'hABCD_5555) begin n_bad++; $display("FAIL wide2 got %b/%h want 01/abcd5555", vo2, do2); end
   endtask

   task automatic test_random();
      bit          v, ms, sy;
      int          s;
      logic [15:0] d;
      logic [15:0] a_v, e_v;
      logic [63:0] a_d, e_d;
      int          a_p;
      logic        a_e;
      do_reset();
      model_reset();
      ms = 1'b0;
      for (int c = 0; c < 600; c++) begin
         v  = ($urandom_range(0, 9) < 5);
         if ($urandom_range(0, 7) == 0) ms = ~ms;
         sy = !ms && ($urandom_range(0, 15) == 0);
         s  = $urandom_range(0, 3);
         d  = 16'($urandom);
         drive(v, ms, s, d, sy);
         model_step(v, ms, sy, s, d);
         for (int k = 0; k < 3; k++) begin
            case (k)
               0:       begin a_v = 16'(vo0); a_d = 64'(do0); a_p = int'(lp0); a_e = er0; end
               1:       begin a_v = 16'(vo1); a_d = 64'(do1); a_p = int'(lp1); a_e = er1; end
               default: begin a_v = 16'(vo2); a_d = 64'(do2); a_p = int'(lp2); a_e = er2; end
            endcase
            e_v = (m_hit[k] >= 0) ? (16'd1 << m_hit[k]) : 16'd0;
            e_d = 64'd0;
            for (int i = 0; i < nch_of[k]; i++) e_d = e_d | (64'(m_lane[k][i]) << (i * w_of[k]));
            n_cmp++;
            if (a_v !== e_v || a_d !== e_d || a_p !== m_ptr[k] || a_e !== m_err[k]) begin
               n_bad++;
               $display("FAIL rand c%0d u%0d got v=%h d=%h p=%0d e=%b want v=%h d=%h p=%0d e=%b",
                        c, k, a_v, a_d, a_p, a_e, e_v, e_d, m_ptr[k], m_err[k]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_rr_stripe();
      test_idle_rewind();
      test_explicit_sel();
      test_sync();
      test_async_reset();
      test_wide();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
